// File: rtl/alarm_pkg.sv
// Shared types, digit indices, wrap limits and BCD helpers for the alarm clock core.
package alarm_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } mode_t;

  localparam logic [2:0] SEC_U = 3'd0;
  localparam logic [2:0] SEC_T = 3'd1;
  localparam logic [2:0] MIN_U = 3'd2;
  localparam logic [2:0] MIN_T = 3'd3;
  localparam logic [2:0] HR_U  = 3'd4;
  localparam logic [2:0] HR_T  = 3'd5;

  localparam logic [3:0] SEC_U_MAX  = 4'd9;
  localparam logic [3:0] SEC_T_MAX  = 4'd5;
  localparam logic [3:0] MIN_U_MAX  = 4'd9;
  localparam logic [3:0] MIN_T_MAX  = 4'd5;
  localparam logic [3:0] HR_T_MAX   = 4'd2;
  localparam logic [3:0] HR_U_MAX   = 4'd9;
  localparam logic [3:0] HR_U_MAX_2 = 4'd3;   // hrU limit once hrT = 2

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } bcd_time_t;

  // Single BCD digit increment with wrap at lim.
  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  // Set-mode increment of one digit, no carry into neighbours.
  function automatic bcd_time_t inc_digit(input bcd_time_t t, input logic [2:0] idx);
    bcd_time_t r;
    r = t;
    case (idx)
      SEC_U: r.sec_u = wrap_inc(t.sec_u, SEC_U_MAX);
      SEC_T: r.sec_t = wrap_inc(t.sec_t, SEC_T_MAX);
      MIN_U: r.min_u = wrap_inc(t.min_u, MIN_U_MAX);
      MIN_T: r.min_t = wrap_inc(t.min_t, MIN_T_MAX);
      HR_U:  r.hr_u  = wrap_inc(t.hr_u, (t.hr_t == HR_T_MAX) ? HR_U_MAX_2 : HR_U_MAX);
      HR_T: begin
        r.hr_t = wrap_inc(t.hr_t, HR_T_MAX);
        if ((r.hr_t == HR_T_MAX) && (t.hr_u > HR_U_MAX_2)) r.hr_u = HR_U_MAX_2;
      end
      default: ;
    endcase
    return r;
  endfunction

  // One-second advance with full carry, 23:59:59 wraps to 00:00:00.
  function automatic bcd_time_t advance_second(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    r.sec_u = wrap_inc(t.sec_u, SEC_U_MAX);
    if (t.sec_u == SEC_U_MAX) begin
      r.sec_t = wrap_inc(t.sec_t, SEC_T_MAX);
      if (t.sec_t == SEC_T_MAX) begin
        r.min_u = wrap_inc(t.min_u, MIN_U_MAX);
        if (t.min_u == MIN_U_MAX) begin
          r.min_t = wrap_inc(t.min_t, MIN_T_MAX);
          if (t.min_t == MIN_T_MAX) begin
            if ((t.hr_t == HR_T_MAX) && (t.hr_u == HR_U_MAX_2)) begin
              r.hr_t = 4'd0;
              r.hr_u = 4'd0;
            end else begin
              r.hr_u = wrap_inc(t.hr_u, HR_U_MAX);
              if (t.hr_u == HR_U_MAX) r.hr_t = t.hr_t + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // 24-hour BCD hour to 12-hour display: {pm, tens, units}.
  function automatic logic [8:0] hour_12(input logic [3:0] ht, input logic [3:0] hu);
    logic [4:0] h;
    logic [4:0] d;
    logic       is_pm;
    h = 5'(ht) * 5'd10 + 5'(hu);
    if (h == 5'd0)       d = 5'd12;
    else if (h > 5'd12)  d = h - 5'd12;
    else                 d = h;
    is_pm = (h >= 5'd12);
    if (d >= 5'd10) return {is_pm, 4'd1, 4'(d - 5'd10)};
    return {is_pm, 4'd0, 4'(d)};
  endfunction

endpackage

// File: rtl/alarm_timekeeper_debounce.sv
// Raw button to single-cycle press pulse: 2-flop synchroniser, stability counter, rising edge.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on accepted rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_pulse <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_s2;
        r_pulse <= r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alarm_timekeeper.sv
// BCD time-of-day core with set modes, hh:mm alarm with latched ring, optional 12-hour view.
module alarm_timekeeper
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC     = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned HOUR_12         = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       switch_select_in,
  input  logic       increment_in,
  input  logic       alarm_enable,
  input  logic       dismiss_in,
  output logic [3:0] secU,
  output logic [3:0] secT,
  output logic [3:0] minU,
  output logic [3:0] minT,
  output logic [3:0] hrU,
  output logic [3:0] hrT,
  output logic [2:0] sel_digit,
  output logic       pm,
  output logic       alarm_ring,
  output logic       tick
);

  localparam int unsigned PW = $clog2(CLK_PER_SEC);

  mode_t     r_mode;
  logic [2:0] r_sel;
  logic [PW-1:0] r_presc;
  logic      r_tick;
  logic      r_ring;
  bcd_time_t r_time;
  bcd_time_t r_alarm;

  mode_t     w_mode;
  logic      w_sel_p;
  logic      w_inc_p;
  logic      w_dis_p;
  logic      w_tick_now;
  logic      w_match;
  bcd_time_t w_next;
  bcd_time_t w_view;
  logic [8:0] w_hr12;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .reset(reset), .i_raw(switch_select_in), .o_pulse(w_sel_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .reset(reset), .i_raw(increment_in), .o_pulse(w_inc_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dis (
    .clk(clk), .reset(reset), .i_raw(dismiss_in), .o_pulse(w_dis_p));

  // Mode from level inputs; set_time has priority.
  always_comb begin
    w_mode = RUN;
    if (set_time)       w_mode = SET_TIME;
    else if (set_alarm) w_mode = SET_ALARM;
  end

  assign w_tick_now = (w_mode == RUN) && (r_presc == PW'(CLK_PER_SEC - 1));
  assign w_next     = advance_second(r_time);
  assign w_match    = (w_next.sec_t == 4'd0) && (w_next.sec_u == 4'd0) &&
                      (w_next.min_u == r_alarm.min_u) && (w_next.min_t == r_alarm.min_t) &&
                      (w_next.hr_u == r_alarm.hr_u) && (w_next.hr_t == r_alarm.hr_t);

  // Prescaler runs only in RUN and restarts from 0 whenever a set mode is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick_now;
      if ((w_mode != RUN) || w_tick_now) r_presc <= '0;
      else                               r_presc <= r_presc + PW'(1);
    end
  end

  // Time/alarm registers, digit selection and mode tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode  <= RUN;
      r_sel   <= SEC_U;
      r_time  <= '0;
      r_alarm <= '0;
    end else begin
      r_mode <= w_mode;
      if (w_tick_now) r_time <= w_next;
      if (w_mode != r_mode) begin
        r_sel <= SEC_U;
      end else if (w_mode != RUN) begin
        if (w_sel_p) r_sel <= (r_sel == HR_T) ? SEC_U : r_sel + 3'd1;
        if (w_inc_p) begin
          if (w_mode == SET_TIME)  r_time  <= inc_digit(r_time, r_sel);
          else if (r_sel >= MIN_U) r_alarm <= inc_digit(r_alarm, r_sel);
        end
      end
    end
  end

  // Ring latch; any clear source overrides a same-cycle match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ring <= 1'b0;
    end else if (w_dis_p || !alarm_enable || (w_mode != RUN)) begin
      r_ring <= 1'b0;
    end else if (w_tick_now && w_match) begin
      r_ring <= 1'b1;
    end
  end

  assign w_view = (r_mode == SET_ALARM) ? r_alarm : r_time;
  assign w_hr12 = hour_12(w_view.hr_t, w_view.hr_u);

  // Display digits straight from registers, with optional 12-hour hour mapping.
  always_comb begin
    secU = w_view.sec_u;
    secT = w_view.sec_t;
    minU = w_view.min_u;
    minT = w_view.min_t;
    hrU  = w_view.hr_u;
    hrT  = w_view.hr_t;
    pm   = 1'b0;
    if (HOUR_12 != 0) begin
      hrT = w_hr12[7:4];
      hrU = w_hr12[3:0];
      pm  = w_hr12[8];
    end
  end

  assign sel_digit  = r_sel;
  assign alarm_ring = r_ring;
  assign tick       = r_tick;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Scoreboard bench for alarm_timekeeper: 24-hour and 12-hour instances share all inputs.
module tb_alarm_timekeeper;

  localparam int unsigned CPS = 10;
  localparam int unsigned DB  = 4;
  localparam int B_SEL = 0;
  localparam int B_INC = 1;
  localparam int B_DIS = 2;
  localparam logic [31:0] M_ALL  = 32'h1FFF_FFFF;
  localparam logic [31:0] M_RING = 32'h0000_0001;
  localparam logic [31:0] M_SECU = 32'h0000_01E0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_time = 1'b0, set_alarm = 1'b0, sw = 1'b0, inc = 1'b0, alarm_enable = 1'b0, dis = 1'b0;

  logic [3:0] a_secU, a_secT, a_minU, a_minT, a_hrU, a_hrT;
  logic [2:0] a_sel;
  logic a_pm, a_ring, a_tick;
  logic [3:0] b_secU, b_secT, b_minU, b_minT, b_hrU, b_hrT;
  logic [2:0] b_sel;
  logic b_pm, b_ring, b_tick;

  int n_checks = 0;
  int n_errors = 0;
  int ticks;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];
  int          which_q[$];

  always #5 clk = ~clk;

  alarm_timekeeper #(.CLK_PER_SEC(CPS), .DEBOUNCE_CYCLES(DB), .HOUR_12(0)) dut24 (
    .clk(clk), .reset(reset), .set_time(set_time), .set_alarm(set_alarm),
    .switch_select_in(sw), .increment_in(inc), .alarm_enable(alarm_enable), .dismiss_in(dis),
    .secU(a_secU), .secT(a_secT), .minU(a_minU), .minT(a_minT), .hrU(a_hrU), .hrT(a_hrT),
    .sel_digit(a_sel), .pm(a_pm), .alarm_ring(a_ring), .tick(a_tick));

  alarm_timekeeper #(.CLK_PER_SEC(CPS), .DEBOUNCE_CYCLES(DB), .HOUR_12(1)) dut12 (
    .clk(clk), .reset(reset), .set_time(set_time), .set_alarm(set_alarm),
    .switch_select_in(sw), .increment_in(inc), .alarm_enable(alarm_enable), .dismiss_in(dis),
    .secU(b_secU), .secT(b_secT), .minU(b_minU), .minT(b_minT), .hrU(b_hrU), .hrT(b_hrT),
    .sel_digit(b_sel), .pm(b_pm), .alarm_ring(b_ring), .tick(b_tick));

  function automatic logic [31:0] obs24();
    return {3'b0, a_hrT, a_hrU, a_minT, a_minU, a_secT, a_secU, a_sel, a_pm, a_ring};
  endfunction

  function automatic logic [31:0] obs12();
    return {3'b0, b_hrT, b_hrU, b_minT, b_minU, b_secT, b_secU, b_sel, b_pm, b_ring};
  endfunction

  // Expected display word from integer hour/minute/second as shown on the digits.
  function automatic logic [31:0] mk(input int h, input int m, input int s,
                                     input int sel, input int p, input int ring);
    return {3'b0, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            3'(sel), 1'(p), 1'(ring)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp, input logic [31:0] mask,
                      input int which);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    mask_q.push_back(mask);
    which_q.push_back(which);
  endtask

  task automatic pop_cmp();
    string t;
    logic [31:0] e, m, o;
    int w;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      w = which_q.pop_front();
      o = (w == 1) ? obs12() : obs24();
      check(t, o & m, e & m);
    end
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      B_SEL:   sw  = v;
      B_INC:   inc = v;
      default: dis = v;
    endcase
  endtask

  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(which, 1'b1);
      repeat (DB + 3) @(negedge clk);
      drive(which, 1'b0);
      repeat (DB + 4) @(negedge clk);
    end
  endtask

  task automatic set_mode(input logic st, input logic sa);
    @(negedge clk);
    set_time  = st;
    set_alarm = sa;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    push("reset_24", mk(0, 0, 0, 0, 0, 0), M_ALL, 0);
    push("reset_12", mk(12, 0, 0, 0, 0, 0), M_ALL, 1);
    pop_cmp();
    set_time = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Short increment glitch is filtered
    push("glitch_filtered", mk(0, 0, 0, 0, 0, 0), M_ALL, 0);
    @(negedge clk);
    inc = 1'b1;
    #30 inc = 1'b0;
    repeat (10) @(negedge clk);
    pop_cmp();

    // Exact press latency: update on edge N+6
    @(negedge clk);
    inc = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 push("latency_n5", mk(0, 0, 0, 0, 0, 0), M_SECU, 0);
    pop_cmp();
    @(posedge clk);
    #1 push("latency_n6", mk(0, 0, 1, 0, 0, 0), M_SECU, 0);
    pop_cmp();
    repeat (6) @(negedge clk);
    inc = 1'b0;
    repeat (10) @(negedge clk);
    push("held_one_pulse", mk(0, 0, 1, 0, 0, 0), M_ALL, 0);
    pop_cmp();

    // Digit selection and minute wrap
    push("sel_2", mk(0, 0, 1, 2, 0, 0), M_ALL, 0);
    press(B_SEL, 2);
    pop_cmp();
    push("minu_x12", mk(0, 2, 1, 2, 0, 0), M_ALL, 0);
    press(B_INC, 12);
    pop_cmp();
    push("sel_5", mk(0, 2, 1, 5, 0, 0), M_ALL, 0);
    press(B_SEL, 3);
    pop_cmp();
    push("sel_wrap_0", mk(0, 2, 1, 0, 0, 0), M_ALL, 0);
    press(B_SEL, 1);
    pop_cmp();

    // Preload 23:59:58, including hrT forcing hrU down to 3
    press(B_INC, 7);
    press(B_SEL, 1);
    press(B_INC, 5);
    press(B_SEL, 1);
    press(B_INC, 7);
    press(B_SEL, 1);
    press(B_INC, 5);
    press(B_SEL, 1);
    press(B_INC, 5);
    press(B_SEL, 1);
    push("hrt_to_1", mk(15, 59, 58, 5, 0, 0), M_ALL, 0);
    press(B_INC, 1);
    pop_cmp();
    push("hrt_force_hru", mk(23, 59, 58, 5, 0, 0), M_ALL, 0);
    push("h12_2359", mk(11, 59, 58, 5, 1, 0), M_ALL, 1);
    press(B_INC, 1);
    pop_cmp();

    // Run 20 cycles across midnight
    @(negedge clk);
    set_time = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (a_tick) ticks++;
    end
    set_time = 1'b1;
    check("tick_count", 32'(ticks), 32'd2);
    push("midnight_wrap", mk(0, 0, 0, 0, 0, 0), M_ALL, 0);
    push("h12_midnight", mk(12, 0, 0, 0, 0, 0), M_ALL, 1);
    pop_cmp();

    // Alarm set to 00:01, time to 00:00:59
    set_mode(1'b0, 1'b1);
    push("alarm_sel0_ignored", mk(0, 0, 0, 0, 0, 0), M_ALL, 0);
    press(B_INC, 1);
    pop_cmp();
    press(B_SEL, 2);
    push("alarm_view", mk(0, 1, 0, 2, 0, 0), M_ALL, 0);
    press(B_INC, 1);
    pop_cmp();
    set_mode(1'b1, 1'b0);
    press(B_INC, 9);
    press(B_SEL, 1);
    push("time_0059", mk(0, 0, 59, 1, 0, 0), M_ALL, 0);
    press(B_INC, 5);
    pop_cmp();
    alarm_enable = 1'b1;

    // Ring on the matching tick, then dismiss clears at N+6
    @(negedge clk);
    set_time = 1'b0;
    repeat (9) @(posedge clk);
    #1 push("ring_before_match", 32'd0, M_RING, 0);
    pop_cmp();
    @(posedge clk);
    #1 push("ring_on_match", mk(0, 1, 0, 0, 0, 1), M_ALL, 0);
    pop_cmp();
    @(negedge clk);
    dis = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 push("dismiss_n5", 32'd1, M_RING, 0);
    pop_cmp();
    @(posedge clk);
    #1 push("dismiss_n6", 32'd0, M_RING, 0);
    pop_cmp();
    repeat (4) @(negedge clk);
    dis = 1'b0;
    repeat (DB + 4) @(negedge clk);

    // Reset mid-press returns everything to reset values at once
    @(negedge clk);
    inc = 1'b1;
    repeat (3) @(negedge clk);
    set_time = 1'b1;
    #2 reset = 1'b1;
    #1 push("reset_mid_24", mk(0, 0, 0, 0, 0, 0), M_ALL, 0);
    push("reset_mid_12", mk(12, 0, 0, 0, 0, 0), M_ALL, 1);
    pop_cmp();
    inc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    set_mode(1'b0, 1'b1);
    push("alarm_after_reset", mk(0, 0, 0, 0, 0, 0), M_ALL, 0);
    pop_cmp();
    press(B_SEL, 2);
    press(B_INC, 1);
    set_mode(1'b1, 1'b0);
    press(B_INC, 9);
    press(B_SEL, 1);
    press(B_INC, 5);

    // Dismiss pulse lands on the matching edge: clear wins
    @(negedge clk);
    set_time = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dis = 1'b1;
    repeat (7) @(posedge clk);
    #1 push("dismiss_beats_match", mk(0, 1, 0, 0, 0, 0), M_ALL, 0);
    pop_cmp();
    repeat (4) @(negedge clk);
    dis = 1'b0;
    repeat (12) @(negedge clk);
    push("ring_stays_low", 32'd0, M_RING, 0);
    pop_cmp();

    // 12-hour view of 13:05:00
    set_time = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    press(B_SEL, 2);
    press(B_INC, 5);
    press(B_SEL, 2);
    press(B_INC, 3);
    press(B_SEL, 1);
    push("time_1305", mk(13, 5, 0, 5, 0, 0), M_ALL, 0);
    push("h12_1305", mk(1, 5, 0, 5, 1, 0), M_ALL, 1);
    press(B_INC, 1);
    pop_cmp();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
